// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, bubble encoding and word type for the processor pipeline
package proc_pkg;

  localparam int DWIDTH_DEF = 32;

  // Instruction word used as the pipeline bubble on reset or flush
  localparam logic [DWIDTH_DEF-1:0] NOP_INST = 32'h0000_0000;

  typedef logic [DWIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - one pipeline field register with async reset, hold and synchronous clear
module pipe_field_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Clear (bubble) wins over hold; hold wins over a normal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (clear) begin
      r_q <= RESET_VAL;
    end else if (!hold) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID/EX pipeline register with stall, valid and optional flush (DECODE_FLUSH_EN)
import proc_pkg::*;

module decode_stage #(
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter logic [DWIDTH-1:0] NOP_INST = proc_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
`ifdef DECODE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] immed,
  input  logic [DWIDTH-1:0] inst,
  input  logic [DWIDTH-1:0] Rd1,
  input  logic [DWIDTH-1:0] Rd2,
  output logic [DWIDTH-1:0] stored_addr,
  output logic [DWIDTH-1:0] stored_immed,
  output logic [DWIDTH-1:0] stored_inst,
  output logic [DWIDTH-1:0] stored_Rd1,
  output logic [DWIDTH-1:0] stored_Rd2,
  output logic              valid_out
);

  logic w_flush;

`ifdef DECODE_FLUSH_EN
  assign w_flush = flush;
`else
  // Without the flush port only reset inserts a bubble
  assign w_flush = 1'b0;
`endif

  pipe_field_reg #(.WIDTH(DWIDTH), .RESET_VAL('0)) u_addr_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(addr), .q(stored_addr)
  );

  pipe_field_reg #(.WIDTH(DWIDTH), .RESET_VAL('0)) u_immed_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(immed), .q(stored_immed)
  );

  pipe_field_reg #(.WIDTH(DWIDTH), .RESET_VAL(NOP_INST)) u_inst_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(inst), .q(stored_inst)
  );

  pipe_field_reg #(.WIDTH(DWIDTH), .RESET_VAL('0)) u_rd1_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(Rd1), .q(stored_Rd1)
  );

  pipe_field_reg #(.WIDTH(DWIDTH), .RESET_VAL('0)) u_rd2_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(Rd2), .q(stored_Rd2)
  );

  pipe_field_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_reg (
    .clk(clk), .rst_n(rst), .hold(stall), .clear(w_flush), .d(valid_in), .q(valid_out)
  );

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;
  import proc_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  logic  valid_in = 1'b0;
  word_t addr = '0, immed = '0, inst = '0, rd1 = '0, rd2 = '0;
  word_t o_addr, o_immed, o_inst, o_rd1, o_rd2;
  logic  o_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of what the execute stage should be seeing
  word_t m_addr, m_immed, m_inst, m_rd1, m_rd2;
  logic  m_valid;

  decode_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
`ifdef DECODE_FLUSH_EN
    .flush(flush),
`endif
    .valid_in(valid_in), .addr(addr), .immed(immed), .inst(inst), .Rd1(rd1), .Rd2(rd2),
    .stored_addr(o_addr), .stored_immed(o_immed), .stored_inst(o_inst),
    .stored_Rd1(o_rd1), .stored_Rd2(o_rd2), .valid_out(o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  o_addr,  m_addr);
    check({tag, ".immed"}, o_immed, m_immed);
    check({tag, ".inst"},  o_inst,  m_inst);
    check({tag, ".rd1"},   o_rd1,   m_rd1);
    check({tag, ".rd2"},   o_rd2,   m_rd2);
    check({tag, ".valid"}, word_t'(o_valid), word_t'(m_valid));
  endtask

  task automatic model_bubble();
    m_addr = '0; m_immed = '0; m_inst = NOP_INST; m_rd1 = '0; m_rd2 = '0; m_valid = 1'b0;
  endtask

  task automatic drive(input word_t a, input word_t im, input word_t in, input word_t r1,
                       input word_t r2, input logic v);
    addr = a; immed = im; inst = in; rd1 = r1; rd2 = r2; valid_in = v;
  endtask

  // One rising edge: flush > stall > load, then sample 1 time unit later
  task automatic clock_edge();
    logic f;
    @(posedge clk);
`ifdef DECODE_FLUSH_EN
    f = flush;
`else
    f = 1'b0;
`endif
    if (f) model_bubble();
    else if (!stall) begin
      m_addr = addr; m_immed = immed; m_inst = inst; m_rd1 = rd1; m_rd2 = rd2; m_valid = valid_in;
    end
    #1;
  endtask

  initial begin
    // Reset with arbitrary inputs, observed before any clock edge
    model_bubble();
    drive(32'd8, 32'd10, 32'h18C7_F000, 32'd31, 32'd3, 1'b1);
    #2;
    check_all("reset");
    check("reset.inst_nop", o_inst, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;

    // Capture
    clock_edge();
    check_all("capture");
    check("capture.addr_lit", o_addr, 32'd8);
    check("capture.inst_lit", o_inst, 32'h18C7_F000);
    // Mid-cycle input change must not reach the outputs
    drive(32'd99, 32'd98, 32'hDEAD_BEEF, 32'd97, 32'd96, 1'b0);
    #2;
    check_all("midcycle_hold");

    // Reset asserted between edges clears immediately
    rst = 1'b0;
    model_bubble();
    #1;
    check_all("async_reset");
    #1;
    rst = 1'b1;
    drive(32'd20, 32'd50, 32'h1F38_A000, 32'd28, 32'd10, 1'b1);
    clock_edge();
    check_all("post_reset_capture");
    check("post_reset.immed_lit", o_immed, 32'd50);

    // Stall holds for three edges, release loads the new value
    drive(32'd8, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    clock_edge();
    stall = 1'b1;
    drive(32'd20, 32'd5, 32'd6, 32'd7, 32'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      check_all("stall");
      check("stall.addr_lit", o_addr, 32'd8);
    end
    stall = 1'b0;
    clock_edge();
    check_all("stall_release");
    check("stall_release.addr_lit", o_addr, 32'd20);

`ifdef DECODE_FLUSH_EN
    // Flush beats stall
    drive(32'd44, 32'd45, 32'h1234_5678, 32'd46, 32'd47, 1'b1);
    clock_edge();
    flush = 1'b1;
    stall = 1'b1;
    clock_edge();
    check_all("flush");
    check("flush.inst_nop", o_inst, 32'h0000_0000);
    flush = 1'b0;
    stall = 1'b0;
`endif

    // Width: bit-exact copy of extreme patterns
    drive(32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    clock_edge();
    check_all("width");
    check("width.rd1_lit", o_rd1, 32'hFFFF_FFFF);
    check("width.rd2_lit", o_rd2, 32'h8000_0001);

    // Randomized traffic with occasional stalls, flushes and mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
`ifdef DECODE_FLUSH_EN
      flush = ($urandom_range(0, 7) == 0);
`endif
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        model_bubble();
        #1;
        check_all("rand_reset");
        rst = 1'b1;
      end
      clock_edge();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID/EX pipeline boundary register of the 32-bit processor.
- Captures the fetched PC address, the sign-extended immediate, the raw instruction word and the two register-file read operands (Rd1, Rd2) at the end of the decode cycle.
- Presents the captured values, stable for one full cycle, to the execute stage.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit, plus a valid flag.

Parameters:
- DWIDTH, 32, width of every data/address/instruction bus.
- NOP_INST, 32'h0000_0000, instruction word loaded on reset or flush (bubble encoding).

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold all stored outputs this edge.
- flush  in  1  1 = load bubble this edge (present only with DECODE_FLUSH_EN).
- valid_in  in  1  upstream slot holds a real instruction.
- addr  in  DWIDTH  PC of the instruction in decode.
- immed  in  DWIDTH  extended immediate.
- inst  in  DWIDTH  instruction word.
- Rd1  in  DWIDTH  register-file read data port 1.
- Rd2  in  DWIDTH  register-file read data port 2.
- stored_addr  out  DWIDTH  registered addr.
- stored_immed  out  DWIDTH  registered immed.
- stored_inst  out  DWIDTH  registered inst.
- stored_Rd1  out  DWIDTH  registered Rd1.
- stored_Rd2  out  DWIDTH  registered Rd2.
- valid_out  out  1  registered slot-valid flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs come directly from flops; there is no combinational path from any input to any output.
- Reset, rst=0: immediately, independent of clk, all stored_* = 0 except stored_inst = NOP_INST, and valid_out = 0. Outputs hold these values while rst stays low.
- Reset deassertion is synchronised by the clock edge; the first capture happens on the first rising edge with rst=1.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and stay until the next update.
- Priority at each rising edge (rst=1): flush > stall > load.
  - flush=1: load bubble, i.e. the reset values with valid_out=0, regardless of stall.
  - stall=1 (flush=0): all outputs, including valid_out, hold their values.
  - Otherwise: stored_* <= inputs and valid_out <= valid_in.
- Values are copied bit-exactly: no sign extension, truncation or arithmetic.
- Input changes between edges never affect the outputs.
- Reset asserted mid-operation overrides stall and flush at once and discards the captured contents.

Optional Feature:
- Macro DECODE_FLUSH_EN.
- Defined: the flush port exists and behaves as above.
- Undefined: no flush port; flush is treated as constant 0, and only rst creates a bubble.

Decomposition:
- Shared package proc_pkg holds:
  - DWIDTH_DEF = 32.
  - NOP_INST constant.
  - typedef word_t = logic [DWIDTH-1:0].
- One natural sub-module, pipe_field_reg: a parameterised WIDTH register with async active-low reset, RESET_VAL, hold and clear inputs.
- decode_stage instantiates pipe_field_reg five times (one per data bus) plus one 1-bit instance for valid.

Test Plan:
- Reset: rst=0 with arbitrary inputs, e.g. addr=8 → all stored_* = 0, stored_inst = NOP_INST, valid_out = 0, all without waiting for a clock edge.
- Capture: rst=1, addr=8, immed=10, inst=32'h18C7_F000, Rd1=31, Rd2=3, valid_in=1 → after the next rising edge the outputs equal the inputs and valid_out=1. The outputs are unchanged if the inputs change mid-cycle.
- Reset mid-operation: after the capture test, drive rst=0 between edges → outputs clear immediately. Then rst=1, addr=20, immed=50, inst=32'h1F38_A000, Rd1=28, Rd2=10 → these values appear after the first edge.
- Stall: capture addr=8, then stall=1 while addr=20 for 3 edges → stored_addr stays 8. Drop stall → 20 after the next edge.
- Flush: with DECODE_FLUSH_EN, flush=1 and stall=1 together → after the edge, bubble loaded, stored_inst = NOP_INST and valid_out = 0.
- Width: Rd1=32'hFFFF_FFFF, Rd2=32'h8000_0001 → captured bit-exactly.
